buffer_arbiter: RTL

BUFFER_ARBITER -- requirements
Module: buffer_arbiter

---
 rtl/buffer_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/buffer_arbiter.sv
// Byte FIFO shared by two round-robin readers (compressor, TX echo) with flush and overflow report.
// Optional dropped-byte counter: define BUF_ARB_OVERFLOW_COUNT_EN to build it.
module buffer_arbiter #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_valid,
    input  logic [7:0]            wr_data,
    input  logic                  flush,
    input  logic                  req0,
    input  logic                  req1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic [7:0]            rd_data,
    output logic                  rd_valid0,
    output logic                  rd_valid1,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic [15:0]           ovf_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {StIdle, StPop, StFlush} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    last_q;      // 1: requester 1 was served last
    logic                    rd_valid0_q, rd_valid1_q, overflow_q;
    logic [7:0]              rd_data_q;
    logic                    pick1, pop, clearing, wr_accept, wr_drop;

    assign count    = count_q;
    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign rd_data  = rd_data_q;
    assign rd_valid0 = rd_valid0_q;
    assign rd_valid1 = rd_valid1_q;
    assign overflow = overflow_q;

    // Grants are decided combinationally in IDLE so the read pointer moves in the grant cycle.
    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        pick1   = req1 & (~req0 | ~last_q);
        if (flush) begin
            state_d = StFlush;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!empty && (req0 || req1)) begin
                        state_d = StPop;
                        gnt1    = pick1;
                        gnt0    = ~pick1;
                    end
                end
                StPop:   state_d = StIdle;
                StFlush: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    assign pop       = gnt0 | gnt1;
    assign clearing  = flush | (state_q == StFlush);
    assign wr_accept = wr_valid & ~clearing & (~full | pop);
    assign wr_drop   = wr_valid & ~clearing & full & ~pop;

    always_comb begin
        count_d = count_q;
        if (clearing) begin
            count_d = '0;
        end else if (wr_accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_accept) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_q      <= 1'b1;
            rd_valid0_q <= 1'b0;
            rd_valid1_q <= 1'b0;
            rd_data_q   <= 8'h00;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_valid0_q <= gnt0;
            rd_valid1_q <= gnt1;
            overflow_q  <= wr_drop;
            if (clearing) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_accept) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q  <= rd_ptr_q + 1'b1;
                    rd_data_q <= mem[rd_ptr_q];
                    last_q    <= gnt1;
                end
            end
        end
    end

    // Storage needs no reset; a full-buffer write and pop may hit the same slot (old value is read).
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

`ifdef BUF_ARB_OVERFLOW_COUNT_EN
    logic [15:0] ovf_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_count_q <= 16'h0000;
        end else if (flush) begin
            ovf_count_q <= 16'h0000;
        end else if (wr_drop && (ovf_count_q != 16'hFFFF)) begin
            ovf_count_q <= ovf_count_q + 16'h0001;
        end
    end

    assign ovf_count = ovf_count_q;
`else
    assign ovf_count = 16'h0000;
`endif

endmodule
